// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-entry holding register.
// Define UART_TX_PARAM_PARITY_EN to enable the optional parity bit.
module uart_tx_param #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  Data_ready,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DAT_MAX = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] STP_MAX = BW'(STOP_BITS - 1);

`ifdef UART_TX_PARAM_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bidx_q, bidx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  hfull_q, hfull_d;
   logic [DATA_WIDTH-1:0] hdata_q, hdata_d;
   logic                  load;
   logic                  bit_done;

`ifdef UART_TX_PARAM_PARITY_EN
   logic hpen_q, hpen_d, hptyp_q, hptyp_d;
   logic pen_q, pen_d, par_q, par_d;
`else
   logic unused_par;
   assign unused_par = PAR_EN ^ PAR_TYP;
`endif

   assign bit_done   = (cnt_q == CNT_MAX);
   assign Data_ready = ~hfull_q;
   assign busy       = (state_q != IDLE);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bidx_q  <= '0;
         shift_q <= '0;
         hfull_q <= 1'b0;
         hdata_q <= '0;
`ifdef UART_TX_PARAM_PARITY_EN
         hpen_q  <= 1'b0;
         hptyp_q <= 1'b0;
         pen_q   <= 1'b0;
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
         hfull_q <= hfull_d;
         hdata_q <= hdata_d;
`ifdef UART_TX_PARAM_PARITY_EN
         hpen_q  <= hpen_d;
         hptyp_q <= hptyp_d;
         pen_q   <= pen_d;
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bidx_d  = bidx_q;
      shift_d = shift_q;
      hfull_d = hfull_q;
      hdata_d = hdata_q;
      load    = 1'b0;
`ifdef UART_TX_PARAM_PARITY_EN
      hpen_d  = hpen_q;
      hptyp_d = hptyp_q;
      pen_d   = pen_q;
      par_d   = par_q;
`endif

      if (Data_valid && !hfull_q) begin
         hfull_d = 1'b1;
         hdata_d = P_DATA;
`ifdef UART_TX_PARAM_PARITY_EN
         hpen_d  = PAR_EN;
         hptyp_d = PAR_TYP;
`endif
      end

      unique case (state_q)
         IDLE: load = hfull_q;
         START: begin
            cnt_d = cnt_q + CW'(1);
            if (bit_done) begin
               cnt_d   = '0;
               bidx_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            cnt_d = cnt_q + CW'(1);
            if (bit_done) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               bidx_d  = bidx_q + BW'(1);
               if (bidx_q == DAT_MAX) begin
                  bidx_d  = '0;
`ifdef UART_TX_PARAM_PARITY_EN
                  state_d = pen_q ? PARITY : STOP;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARAM_PARITY_EN
         PARITY: begin
            cnt_d = cnt_q + CW'(1);
            if (bit_done) begin
               cnt_d   = '0;
               bidx_d  = '0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            cnt_d = cnt_q + CW'(1);
            if (bit_done) begin
               cnt_d  = '0;
               bidx_d = bidx_q + BW'(1);
               if (bidx_q == STP_MAX) begin
                  bidx_d  = '0;
                  state_d = IDLE;
                  load    = hfull_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Transfer empties the holding register; acceptance only occurs when it is empty
      if (load) begin
         state_d = START;
         cnt_d   = '0;
         bidx_d  = '0;
         shift_d = hdata_q;
         hfull_d = 1'b0;
`ifdef UART_TX_PARAM_PARITY_EN
         pen_d   = hpen_q;
         par_d   = (^hdata_q) ^ hptyp_q;
`endif
      end
   end

   always_comb begin
      TX_OUT = 1'b1;
      unique case (state_q)
         IDLE:    TX_OUT = 1'b1;
         START:   TX_OUT = 1'b0;
         DATA:    TX_OUT = shift_q[0];
`ifdef UART_TX_PARAM_PARITY_EN
         PARITY:  TX_OUT = par_q;
`endif
         STOP:    TX_OUT = 1'b1;
         default: TX_OUT = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: accepted words queue expected
// frames, a line monitor pops and checks each frame bit by bit.
module tb_uart_tx_param;

   localparam int DW  = 8;
   localparam int CPB = 4;
   localparam int SB  = 1;
`ifdef UART_TX_PARAM_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] P_DATA = '0;
   logic          Data_valid = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic          Data_ready;
   logic          TX_OUT;
   logic          busy;

   typedef struct {
      logic [15:0] bits;
      int          len;
   } frame_t;

   frame_t sb[$];
   int tests = 0;
   int fails = 0;
   int pushed = 0;
   int popped = 0;
   bit mon_stop = 1'b0;
   bit mon_done = 1'b0;

   uart_tx_param #(
      .DATA_WIDTH(DW),
      .CLKS_PER_BIT(CPB),
      .STOP_BITS(SB)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .P_DATA(P_DATA),
      .Data_valid(Data_valid),
      .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP),
      .Data_ready(Data_ready),
      .TX_OUT(TX_OUT),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame as the line should carry it: start, data LSB first, parity, stops
   function automatic frame_t model(input logic [DW-1:0] d,
                                    input logic pe, input logic pt);
      frame_t f;
      int n;
      int ones;
      f.bits = '0;
      n = 0;
      ones = 0;
      f.bits[n] = 1'b0;
      n++;
      for (int i = 0; i < DW; i++) begin
         f.bits[n] = d[i];
         ones += int'(d[i]);
         n++;
      end
      if (pe && PAR_ON) begin
         f.bits[n] = ((ones % 2) == 1) ^ pt;
         n++;
      end
      for (int i = 0; i < SB; i++) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.len = n;
      return f;
   endfunction

   always @(negedge CLK) begin
      if (RST && Data_valid && Data_ready) begin
         sb.push_back(model(P_DATA, PAR_EN, PAR_TYP));
         pushed++;
      end
   end

   task automatic monitor();
      @(negedge CLK);
      while (!mon_stop) begin
         if (TX_OUT === 1'b0) begin
            if (sb.size() == 0) begin
               chk("unexpected_frame", 1, 0);
               for (int k = 0; k < 200 && TX_OUT === 1'b0; k++)
                  @(negedge CLK);
            end else begin
               frame_t e;
               int pos;
               e = sb.pop_front();
               popped++;
               pos = 0;
               for (int b = 0; b < e.len; b++) begin
                  repeat (b * CPB + 1 - pos) @(negedge CLK);
                  pos = b * CPB + 1;
                  chk("frame_bit", int'(TX_OUT), int'(e.bits[b]));
                  chk("frame_busy", int'(busy), 1);
               end
               repeat (e.len * CPB - pos) @(negedge CLK);
               chk("frame_end", int'(busy), int'(!TX_OUT));
            end
         end else begin
            @(negedge CLK);
         end
      end
      mon_done = 1'b1;
   endtask

   task automatic count_busy(output int bc);
      bc = 0;
      while (busy && bc < 400) begin
         bc++;
         @(negedge CLK);
      end
   endtask

   initial begin
      int bc;
      int lows;
      int bsy;
      int rate;
      bit ok;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_tx", int'(TX_OUT), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ready", int'(Data_ready), 1);
      @(posedge CLK);
      #1 RST = 1'b1;
      fork
         monitor();
      join_none

      // Single frame from idle: latency and busy length
      @(posedge CLK);
      #1;
      Data_valid = 1'b1;
      P_DATA = 8'hA5;
      PAR_EN = 1'b1;
      PAR_TYP = 1'b0;
      @(negedge CLK);
      chk("ready_before", int'(Data_ready), 1);
      @(posedge CLK);
      #1;
      Data_valid = 1'b0;
      P_DATA = 8'h00;
      PAR_EN = 1'b0;
      PAR_TYP = 1'b1;
      @(negedge CLK);
      chk("lat_tx", int'(TX_OUT), 1);
      chk("lat_busy", int'(busy), 0);
      chk("lat_ready", int'(Data_ready), 0);
      @(negedge CLK);
      chk("start_tx", int'(TX_OUT), 0);
      chk("start_busy", int'(busy), 1);
      chk("start_ready", int'(Data_ready), 1);
      count_busy(bc);
      chk("busy_len", bc, model(8'hA5, 1'b1, 1'b0).len * CPB);

      // Back-to-back frames plus a third word offered while full
      @(posedge CLK);
      #1;
      Data_valid = 1'b1;
      P_DATA = 8'h0F;
      PAR_EN = 1'b1;
      PAR_TYP = 1'b0;
      @(posedge CLK);
      #1 Data_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      fork
         count_busy(bc);
         begin
            repeat (5) @(posedge CLK);
            #1;
            Data_valid = 1'b1;
            P_DATA = 8'hF0;
            @(posedge CLK);
            #1 P_DATA = 8'h33;
            @(negedge CLK);
            chk("ready_full", int'(Data_ready), 0);
            repeat (20) @(posedge CLK);
            #1 Data_valid = 1'b0;
         end
      join
      chk("b2b_busy_len", bc,
          (model(8'h0F, 1'b1, 1'b0).len + model(8'hF0, 1'b1, 1'b0).len) * CPB);
      chk("b2b_frames", popped, 3);

      // Randomised traffic: alternating sparse and dense offer phases
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge CLK);
         #1;
         rate = ((cyc / 400) % 2 == 1) ? 70 : 3;
         Data_valid = ($urandom % 100) < rate;
         P_DATA = DW'($urandom);
         PAR_EN = 1'($urandom);
         PAR_TYP = 1'($urandom);
      end
      @(posedge CLK);
      #1 Data_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 3000 && !ok; k++) begin
         @(negedge CLK);
         ok = (sb.size() == 0) && !busy && Data_ready;
      end
      chk("drain_done", int'(ok), 1);
      chk("frames_popped", popped, pushed);

      mon_stop = 1'b1;
      for (int k = 0; k < 500 && !mon_done; k++) @(negedge CLK);
      chk("monitor_stopped", int'(mon_done), 1);
      sb.delete();

      // Reset in mid-frame with a word waiting in the holding register
      @(posedge CLK);
      #1;
      Data_valid = 1'b1;
      P_DATA = 8'h3C;
      PAR_EN = 1'b1;
      PAR_TYP = 1'b1;
      @(posedge CLK);
      #1 Data_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      @(posedge CLK);
      #1;
      Data_valid = 1'b1;
      P_DATA = 8'hC3;
      @(posedge CLK);
      #1 Data_valid = 1'b0;
      repeat (7) @(posedge CLK);
      #1;
      RST = 1'b0;
      Data_valid = 1'b1;
      P_DATA = 8'h55;
      @(negedge CLK);
      chk("mid_busy", int'(busy), 1);
      chk("mid_full", int'(Data_ready), 0);
      @(negedge CLK);
      chk("rst_tx", int'(TX_OUT), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(Data_ready), 1);
      @(negedge CLK);
      chk("rst_hold_ready", int'(Data_ready), 1);
      chk("rst_hold_busy", int'(busy), 0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      Data_valid = 1'b0;
      lows = 0;
      bsy = 0;
      repeat (150) begin
         @(negedge CLK);
         if (TX_OUT !== 1'b1) lows++;
         if (busy !== 1'b0) bsy++;
      end
      chk("post_rst_line_low", lows, 0);
      chk("post_rst_busy", bsy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, CLK cycles per serial bit (legal 1..65535).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 SHALL have port CLK input 1, single clock; all logic on rising edge.
REQ-005 SHALL have port RST input 1, reset; synchronous, active-low.
REQ-006 SHALL have port P_DATA input DATA_WIDTH, parallel word to send.
REQ-007 SHALL have port Data_valid input 1, word-offer strobe.
REQ-008 SHALL have port PAR_EN input 1, parity-bit enable for offered word.
REQ-009 SHALL have port PAR_TYP input 1, parity type for offered word: 0 even, 1 odd.
REQ-010 SHALL have port Data_ready output 1, holding register empty; word accepted when Data_valid and Data_ready are both high at a rising edge.
REQ-011 SHALL have port TX_OUT output 1, serial line, idle high.
REQ-012 SHALL have port busy output 1, high while a frame is on the line.

Function
REQ-013 SHALL capture P_DATA, PAR_EN and PAR_TYP into a one-entry holding register on acceptance; Data_ready low while the register is full.
REQ-014 SHALL ignore Data_valid while Data_ready is low; holding register and line unchanged.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; each bit lasts exactly CLKS_PER_BIT cycles, timed by a bit counter.
REQ-016 IDLE->START when holding register full; transfer moves word into the shift register and sets Data_ready high in the same cycle.
REQ-017 TX_OUT SHALL go low in the cycle after acceptance when the FSM was in IDLE (one-cycle latency).
REQ-018 START->DATA after one bit time; DATA sends DATA_WIDTH bits LSB first.
REQ-019 DATA->PARITY if the latched PAR_EN is 1, else DATA->STOP.
REQ-020 Parity bit SHALL equal XOR of all data bits XOR latched PAR_TYP.
REQ-021 STOP drives TX_OUT high for STOP_BITS bit times.
REQ-022 At end of STOP: ->START with no idle gap if the holding register is full, else ->IDLE.
REQ-023 TX_OUT SHALL be 1 in IDLE; 0 in START; current shift bit in DATA; parity in PARITY; 1 in STOP.
REQ-024 busy SHALL be high in START, DATA, PARITY and STOP, low in IDLE.
REQ-025 P_DATA, PAR_EN and PAR_TYP changes after acceptance SHALL not affect the frame in flight or the held word.

Reset
REQ-026 RST low at a rising edge SHALL force IDLE, TX_OUT=1, busy=0, Data_ready=1, holding register empty, counters zero.
REQ-027 Reset mid-frame SHALL abort the frame and discard the held word; no partial continuation after release.
REQ-028 Data_valid SHALL be ignored in any cycle where RST is low.

Configuration
REQ-029 Macro UART_TX_PARAM_PARITY_EN defined: parity behaviour per REQ-019/REQ-020.
REQ-030 Macro undefined: PARITY state absent; PAR_EN and PAR_TYP present but ignored; DATA always ->STOP.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, macro defined unless stated)
REQ-031 Offer 0xA5, PAR_EN=1, PAR_TYP=0 from IDLE -> TX_OUT each 4 cycles: 0,1,0,1,0,0,1,0,1,0,1; busy high 44 cycles; then idle high.
REQ-032 Offer 0xA5, PAR_EN=1, PAR_TYP=1 -> parity bit 1; PAR_EN=0 -> 10-bit frame, busy high 40 cycles.
REQ-033 Offer 0x0F, then offer 0xF0 while first in flight -> second start bit immediately follows first stop bit, busy high 88 contiguous cycles, Data_ready low from 2nd acceptance until 2nd START.
REQ-034 Offer a third word while holding register full -> Data_ready low, word ignored, only two frames on the line.
REQ-035 Assert RST low at cycle 10 of a frame -> next edge TX_OUT=1, busy=0, Data_ready=1; held word never transmitted.
REQ-036 Macro undefined, offer 0xA5 with PAR_EN=1 -> 10-bit frame without parity, busy high 40 cycles.
